// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory port between instruction fetch and the MEM stage
//
// Data requests win arbitration, but after FETCH_STARVE_MAX consecutive data grants with a fetch
// pending the fetch is forced through. One bus transaction is outstanding at a time:
// IDLE (arbitrate) -> BUS (wait for bus_ack) -> RESP (one-cycle ack) -> IDLE.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN adds a bus_ack timeout of TIMEOUT_CYCLES BUS cycles
// that completes the transaction with err=1 and zeroed read data.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   if_req/if_addr -> if_ack/if_rdata   fetch port (read-only, word aligned on the bus)
//   d_op/d_addr/d_wdata/d_wrstb -> d_ack/d_rdata   data port (LOAD/STORE, NONE or 2'b11 idle)
//   err                             timeout flag, pulses with the ack
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wrstb -> bus_ack/bus_rdata   external memory bus
package types;
    typedef logic [31:0] u32_t;
    typedef logic [3:0]  wrstb_t;
    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_op_e;
endpackage

module mem_bus_arbiter
    import types::*;
#(
    parameter int unsigned FETCH_STARVE_MAX = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic [1:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wrstb,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wrstb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    if (FETCH_STARVE_MAX < 1 || FETCH_STARVE_MAX > 15) begin : g_bad_starve
        $error("FETCH_STARVE_MAX must be 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be 1..255");
    end

    localparam logic [3:0] STARVE_MAX = 4'(FETCH_STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    state_e state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic sel_d_q, sel_d_d;
    logic bus_req_q, bus_req_d;
    logic bus_we_q, bus_we_d;
    u32_t bus_addr_q, bus_addr_d;
    u32_t bus_wdata_q, bus_wdata_d;
    wrstb_t bus_wrstb_q, bus_wrstb_d;
    logic if_ack_q, if_ack_d;
    logic d_ack_q, d_ack_d;
    u32_t if_rdata_q, if_rdata_d;
    u32_t d_rdata_q, d_rdata_d;
    logic d_valid, fetch_win, timeout;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_q, wait_d;
    logic err_q, err_d;
`endif

    always_comb begin
        d_valid     = d_op == MEM_LOAD || d_op == MEM_STORE;
        // the starvation limit only overrides data when a fetch is actually waiting
        fetch_win   = if_req && (!d_valid || streak_q == STARVE_MAX);
`ifdef MEM_ARB_TIMEOUT_EN
        timeout     = !bus_ack && wait_q == TO_LAST;
        wait_d      = state_q == BUS ? wait_q + 8'd1 : '0;
        err_d       = 1'b0;
`else
        timeout     = 1'b0;
`endif
        state_d     = state_q;
        streak_d    = streak_q;
        sel_d_d     = sel_d_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wrstb_d = bus_wrstb_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (d_valid || if_req) begin
                    state_d     = BUS;
                    bus_req_d   = 1'b1;
                    sel_d_d     = !fetch_win;
                    bus_we_d    = !fetch_win && d_op == MEM_STORE;
                    bus_addr_d  = fetch_win ? (if_addr & ~32'h3) : d_addr;
                    bus_wdata_d = bus_we_d ? d_wdata : '0;
                    bus_wrstb_d = bus_we_d ? d_wrstb : '0;
                    // a data grant with a fetch waiting implies streak < max, so +1 cannot pass it
                    streak_d    = (fetch_win || !if_req) ? '0 : streak_q + 4'd1;
                end
            end
            BUS: begin
                if (bus_ack || timeout) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    if_ack_d  = !sel_d_q;
                    d_ack_d   = sel_d_q;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_d     = timeout;
`endif
                    if (!bus_we_q && sel_d_q) d_rdata_d = timeout ? '0 : bus_rdata;
                    if (!sel_d_q) if_rdata_d = timeout ? '0 : bus_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            sel_d_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wrstb_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            sel_d_q     <= sel_d_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wrstb_q <= bus_wrstb_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_q      <= wait_d;
            err_q       <= err_d;
`endif
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wrstb = bus_wrstb_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter with directed requester traffic
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic [1:0]  d_op = 2'b11;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wrstb = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wrstb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.FETCH_STARVE_MAX(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata), .d_wrstb(d_wrstb),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wrstb(bus_wrstb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wrstb;
    } bus_t;
    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] if_rd;
        logic [31:0] d_rd;
    } ack_t;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wrstb;
    } dreq_t;

    bus_t        exp_bus[$];
    ack_t        exp_ack[$];
    logic [31:0] if_pend[$];
    dreq_t       d_pend[$];
    int n_chk = 0;
    int n_fail = 0;
    int ack_delay = 0;
    int bcnt = 0;
    logic bus_req_prev = 1'b0;
    bus_t cur_bus;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] st);
        bus_t b;
        b.addr = a; b.we = we; b.wdata = wd; b.wrstb = st;
        exp_bus.push_back(b);
    endtask

    task automatic push_ack(input logic is_d, input logic e, input logic [31:0] ifr, input logic [31:0] dr);
        ack_t a;
        a.is_d = is_d; a.err = e; a.if_rd = ifr; a.d_rd = dr;
        exp_ack.push_back(a);
    endtask

    task automatic push_d(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        dreq_t r;
        r.op = op; r.addr = a; r.wdata = wd; r.wrstb = st;
        d_pend.push_back(r);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (exp_ack.size() == 0 && if_pend.size() == 0 && d_pend.size() == 0) break;
        end
        chk({name, "_drain"}, 32'(exp_ack.size() + if_pend.size() + d_pend.size()), 0);
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a == 32'h1000 ? 32'hCAFE_F00D : {a[15:0], 16'hBEEF};
    endfunction

    // requesters: present the head of each pending queue, retire it on its ack
    always @(negedge clk) begin
        if (if_ack && if_pend.size() != 0) if_pend.delete(0);
        if (d_ack && d_pend.size() != 0) d_pend.delete(0);
        if_req  = if_pend.size() != 0;
        if_addr = if_req ? if_pend[0] : '0;
        if (d_pend.size() != 0) begin
            d_op = d_pend[0].op; d_addr = d_pend[0].addr;
            d_wdata = d_pend[0].wdata; d_wrstb = d_pend[0].wrstb;
        end else begin
            d_op = 2'b11; d_addr = '0; d_wdata = '0; d_wrstb = '0;
        end
    end

    // bus slave: acks ack_delay cycles after bus_req is seen (0 = same cycle, -1 = never)
    always @(negedge clk) begin
        bus_ack = 1'b0;
        if (bus_req) begin
            if (bcnt == ack_delay) begin
                bus_ack = 1'b1; bus_rdata = rd_of(bus_addr); bcnt = 0;
            end else bcnt++;
        end else bcnt = 0;
    end

    // monitor: compares every ack and every new bus transaction against the scoreboard
    always @(negedge clk) begin
        ack_t a;
        bus_t b;
        if (if_ack || d_ack) begin
            chk("ack_exclusive", 32'(if_ack & d_ack), 0);
            if (exp_ack.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_ack: if_ack=%b d_ack=%b with no expected completion", if_ack, d_ack);
            end else begin
                a = exp_ack.pop_front();
                chk("ack_port_is_d", 32'(d_ack), 32'(a.is_d));
                chk("ack_err", 32'(err), 32'(a.err));
                chk("if_rdata", if_rdata, a.if_rd);
                chk("d_rdata", d_rdata, a.d_rd);
            end
        end else chk("err_without_ack", 32'(err), 0);
        if (bus_req && !bus_req_prev) begin
            if (exp_bus.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_bus_req: addr got %h with no expected transaction", bus_addr);
            end else begin
                b = exp_bus.pop_front();
                chk("bus_addr", bus_addr, b.addr);
                chk("bus_we", 32'(bus_we), 32'(b.we));
                chk("bus_wdata", bus_wdata, b.wdata);
                chk("bus_wrstb", 32'(bus_wrstb), 32'(b.wrstb));
            end
            cur_bus.addr = bus_addr; cur_bus.wdata = bus_wdata;
        end else if (bus_req) begin
            chk("bus_addr_hold", bus_addr, cur_bus.addr);
            chk("bus_wdata_hold", bus_wdata, cur_bus.wdata);
        end
        bus_req_prev = bus_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset with a fetch pending, then a same-cycle-ack fetch
        if_pend.push_back(32'h0000_1003);
        push_bus(32'h0000_1000, 1'b0, 32'h0, 4'h0);
        push_ack(1'b0, 1'b0, 32'hCAFE_F00D, 32'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 32'({bus_req, bus_we, bus_wrstb, if_ack, d_ack, err}), 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_bus_req", 32'(bus_req), 1);
        chk("no_early_if_ack", 32'(if_ack), 0);
        @(negedge clk);
        chk("if_ack_latency", 32'(if_ack), 1);
        drain("fetch");

        // store vs fetch: data first, store leaves d_rdata alone
        @(posedge clk);
        ack_delay = 1;
        push_d(2'b10, 32'h40, 32'h1234_5678, 4'b0011);
        if_pend.push_back(32'h2000);
        push_bus(32'h40, 1'b1, 32'h1234_5678, 4'b0011);
        push_bus(32'h2000, 1'b0, 32'h0, 4'h0);
        push_ack(1'b1, 1'b0, 32'hCAFE_F00D, 32'h0);
        push_ack(1'b0, 1'b0, 32'h2000_BEEF, 32'h0);
        drain("store_vs_fetch");

        // starvation: D,D,D,D,IF,D,D then the last fetch
        @(posedge clk);
        ack_delay = 0;
        for (int i = 0; i < 6; i++) push_d(2'b01, 32'h100 + 32'(4 * i), 32'h0, 4'h0);
        if_pend.push_back(32'h3000);
        if_pend.push_back(32'h3004);
        push_bus(32'h100, 1'b0, 0, 0); push_ack(1'b1, 1'b0, 32'h2000_BEEF, 32'h0100_BEEF);
        push_bus(32'h104, 1'b0, 0, 0); push_ack(1'b1, 1'b0, 32'h2000_BEEF, 32'h0104_BEEF);
        push_bus(32'h108, 1'b0, 0, 0); push_ack(1'b1, 1'b0, 32'h2000_BEEF, 32'h0108_BEEF);
        push_bus(32'h10C, 1'b0, 0, 0); push_ack(1'b1, 1'b0, 32'h2000_BEEF, 32'h010C_BEEF);
        push_bus(32'h3000, 1'b0, 0, 0); push_ack(1'b0, 1'b0, 32'h3000_BEEF, 32'h010C_BEEF);
        push_bus(32'h110, 1'b0, 0, 0); push_ack(1'b1, 1'b0, 32'h3000_BEEF, 32'h0110_BEEF);
        push_bus(32'h114, 1'b0, 0, 0); push_ack(1'b1, 1'b0, 32'h3000_BEEF, 32'h0114_BEEF);
        push_bus(32'h3004, 1'b0, 0, 0); push_ack(1'b0, 1'b0, 32'h3004_BEEF, 32'h0114_BEEF);
        drain("starvation");

        // reset while in BUS: no ack, same load granted again afterwards
        @(posedge clk);
        ack_delay = -1;
        push_d(2'b01, 32'h200, 32'h0, 4'h0);
        push_bus(32'h200, 1'b0, 0, 0);
        push_bus(32'h200, 1'b0, 0, 0);
        push_ack(1'b1, 1'b0, 32'h0, 32'h0200_BEEF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_req) break;
        end
        chk("midbus_req_seen", 32'(bus_req), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midbus_req_dropped", 32'(bus_req), 0);
        chk("midbus_no_ack", 32'({if_ack, d_ack}), 0);
        ack_delay = 0;
        rst_n = 1'b1;
        drain("reset_mid_bus");

`ifdef MEM_ARB_TIMEOUT_EN
        // load with no bus_ack: 8 BUS cycles, then d_ack with err and zeroed d_rdata
        @(posedge clk);
        ack_delay = -1;
        push_d(2'b01, 32'h300, 32'h0, 4'h0);
        push_bus(32'h300, 1'b0, 0, 0);
        push_ack(1'b1, 1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_req) break;
        end
        n = 0;
        while (bus_req && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_bus_cycles", 32'(n), 8);
        chk("timeout_d_ack", 32'(d_ack), 1);
        chk("timeout_err", 32'(err), 1);
        chk("timeout_d_rdata", d_rdata, 0);
        ack_delay = 0;
        drain("timeout");
`else
        n = 0;
`endif

        repeat (3) @(posedge clk);
        chk("exp_bus_empty", 32'(exp_bus.size()), 0);
        chk("exp_ack_empty", 32'(exp_ack.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
